onfi_sdr_host_seq: RTL and testbench

Host-side ONFI SDR (asynchronous-interface) bus sequencer. It sits directly upstream of the NAND DUT pin model and drives CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n and the 8-bit DQ bus, and it samples RB_x_n. A simple op stream (CMD, ADDR, DIN, DOUT, WAIT_RB) is converted into timed pin waveforms, with all timing in clk cycles. Bench drivers and the future controller feed ops in; the DUT consumes the pin activity.

---
 rtl/onfi_sdr_host_seq_if.sv | 37 +++
 rtl/onfi_sdr_host_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_onfi_sdr_host_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/onfi_sdr_host_seq_if.sv
// Op-stream handshake and ONFI SDR pin bundle between the host sequencer and its peers.
// master = the sequencer itself; slave = op source / NAND pin model side.
interface onfi_sdr_host_seq_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_type;
  logic [7:0] op_data;
  logic       op_last;
  logic       wp_en;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic       err;

  logic       CE_x_n;
  logic       CLE_x;
  logic       ALE_x;
  logic       WE_x_n;
  logic       RE_x_n;
  logic       WP_x_n;
  logic       RB_x_n;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic [7:0] dq_in;

  modport master (
    input  op_valid, op_type, op_data, op_last, wp_en, RB_x_n, dq_in,
    output op_ready, rd_valid, rd_data, done, err,
           CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n, dq_out, dq_oe
  );

  modport slave (
    output op_valid, op_type, op_data, op_last, wp_en, RB_x_n, dq_in,
    input  op_ready, rd_valid, rd_data, done, err,
           CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n, dq_out, dq_oe
  );
endinterface

// File: rtl/onfi_sdr_host_seq.sv
// Host-side ONFI SDR sequencer: turns CMD/ADDR/DIN/DOUT/WAIT_RB ops into cycle-timed pin waveforms.
// Every pin and status output is a flop so the NAND model sees glitch-free edges.
module onfi_sdr_host_seq #(
  parameter int T_WP    = 2,
  parameter int T_WH    = 2,
  parameter int T_RP    = 2,
  parameter int T_RH    = 2,
  parameter int T_WB    = 4,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  onfi_sdr_host_seq_if.master bus
);

  localparam logic [2:0] OP_CMD  = 3'd0;
  localparam logic [2:0] OP_ADDR = 3'd1;
  localparam logic [2:0] OP_DIN  = 3'd2;
  localparam logic [2:0] OP_DOUT = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    WLOW,
    WHIGH,
    RLOW,
    RHIGH,
    WB,
    RBW
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;

  logic       ce_n_q, ce_n_d;
  logic       cle_q, cle_d;
  logic       ale_q, ale_d;
  logic       we_n_q, we_n_d;
  logic       re_n_q, re_n_d;
  logic       dq_oe_q, dq_oe_d;
  logic [7:0] dq_out_q, dq_out_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       op_ready_q, op_ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       last_q, last_d;
  logic       ill_q, ill_d;
  logic       wp_q;
  logic       rb_s1_q, rb_s2_q;

  // State register, pin flops and the RB_x_n synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      to_q       <= '0;
      ce_n_q     <= 1'b1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      we_n_q     <= 1'b1;
      re_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      op_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      ill_q      <= 1'b0;
      wp_q       <= 1'b0;
      rb_s1_q    <= 1'b0;
      rb_s2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      ce_n_q     <= ce_n_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      we_n_q     <= we_n_d;
      re_n_q     <= re_n_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      op_ready_q <= op_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_q     <= last_d;
      ill_q      <= ill_d;
      wp_q       <= bus.wp_en;
      rb_s1_q    <= bus.RB_x_n;
      rb_s2_q    <= rb_s1_q;
    end
  end

  // Next-state and next-pin logic; counters hold "cycles left minus one" in the current phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    ce_n_d     = ce_n_q;
    cle_d      = cle_q;
    ale_d      = ale_q;
    we_n_d     = we_n_q;
    re_n_d     = re_n_q;
    dq_oe_d    = dq_oe_q;
    dq_out_d   = dq_out_q;
    rd_data_d  = rd_data_q;
    op_ready_d = op_ready_q;
    last_d     = last_q;
    ill_d      = ill_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ill_q) begin
          ill_d = 1'b0;
          err_d = 1'b1;
        end else if (bus.op_valid && op_ready_q) begin
          op_ready_d = 1'b0;
          ce_n_d     = 1'b0;
          last_d     = bus.op_last;
          case (bus.op_type)
            OP_CMD, OP_ADDR, OP_DIN: begin
              cle_d    = (bus.op_type == OP_CMD);
              ale_d    = (bus.op_type == OP_ADDR);
              dq_out_d = bus.op_data;
              dq_oe_d  = 1'b1;
              we_n_d   = 1'b0;
              cnt_d    = TO_W'(T_WP - 1);
              state_d  = WLOW;
            end
            OP_DOUT: begin
              dq_oe_d = 1'b0;
              re_n_d  = 1'b0;
              cnt_d   = TO_W'(T_RP - 1);
              state_d = RLOW;
            end
            OP_WAIT: begin
              if (T_WB > 0) begin
                cnt_d   = TO_W'(T_WB - 1);
                state_d = WB;
              end else begin
                to_d    = '0;
                state_d = RBW;
              end
            end
            default: begin
              ill_d = 1'b1;
            end
          endcase
        end else begin
          op_ready_d = 1'b1;
        end
      end

      WLOW: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          cnt_d   = TO_W'(T_WH - 1);
          state_d = WHIGH;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end

      WHIGH: begin
        if (cnt_q == '0) begin
          cle_d   = 1'b0;
          ale_d   = 1'b0;
          dq_oe_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end

      // The byte is captured on the same edge RE_x_n rises, i.e. the end of the low phase.
      RLOW: begin
        if (cnt_q == '0) begin
          re_n_d     = 1'b1;
          rd_data_d  = bus.dq_in;
          rd_valid_d = 1'b1;
          cnt_d      = TO_W'(T_RH - 1);
          state_d    = RHIGH;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end

      RHIGH: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end

      WB: begin
        if (cnt_q == '0) begin
          to_d    = '0;
          state_d = RBW;
        end else begin
          cnt_d = cnt_q - TO_W'(1);
        end
      end

      // Ready wins over timeout on the same edge; the timeout counter saturates at all-ones.
      RBW: begin
        if (rb_s2_q) begin
          done_d = 1'b1;
        end else if (to_q >= TO_W'(TIMEOUT - 1)) begin
          err_d = 1'b1;
        end else if (to_q != '1) begin
          to_d = to_q + TO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (done_d || err_d) begin
      state_d    = IDLE;
      op_ready_d = 1'b1;
      if (last_q) begin
        ce_n_d = 1'b1;
      end
    end
  end

  assign bus.op_ready = op_ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.CE_x_n   = ce_n_q;
  assign bus.CLE_x    = cle_q;
  assign bus.ALE_x    = ale_q;
  assign bus.WE_x_n   = we_n_q;
  assign bus.RE_x_n   = re_n_q;
  assign bus.WP_x_n   = wp_q;
  assign bus.dq_out   = dq_out_q;
  assign bus.dq_oe    = dq_oe_q;

endmodule

// File: tb/tb_onfi_sdr_host_seq.sv
// Directed bench for onfi_sdr_host_seq: a cycle-level op-timeline model checked every cycle,
// plus literal latency/value checks that pin the model.
module tb_onfi_sdr_host_seq;

  localparam int T_WP    = 2;
  localparam int T_WH    = 2;
  localparam int T_RP    = 2;
  localparam int T_RH    = 2;
  localparam int T_WB    = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   checkEn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  onfi_sdr_host_seq_if bus ();

  onfi_sdr_host_seq #(
    .T_WP(T_WP), .T_WH(T_WH), .T_RP(T_RP), .T_RH(T_RH),
    .T_WB(T_WB), .TIMEOUT(TIMEOUT), .TO_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: each accepted op is a timeline indexed by edges since acceptance.
  bit         mBusy;
  bit         mFin;
  int         mK;
  logic [2:0] mType;
  logic       mLast;
  logic       mRb1, mRb2;
  logic       expReady, expRdValid, expDone, expErr;
  logic       expCe, expCle, expAle, expWe, expRe, expWp, expOe;
  logic [7:0] expRdData, expDqOut;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy = 0; mK = 0; mType = 3'd0; mLast = 1'b0; mRb1 = 1'b0; mRb2 = 1'b0;
      expReady = 0; expRdValid = 0; expDone = 0; expErr = 0;
      expCe = 1; expCle = 0; expAle = 0; expWe = 1; expRe = 1; expWp = 0; expOe = 0;
      expRdData = 8'h00; expDqOut = 8'h00;
    end else begin
      mFin = 0;
      expRdValid = 0; expDone = 0; expErr = 0;
      expWp = bus.wp_en;
      if (mBusy) begin
        mK++;
        case (mType)
          3'd0, 3'd1, 3'd2: begin
            if (mK == T_WP) expWe = 1;
            if (mK == T_WP + T_WH) begin
              expDone = 1; expCle = 0; expAle = 0; expOe = 0; mFin = 1;
            end
          end
          3'd3: begin
            if (mK == T_RP) begin
              expRe = 1; expRdValid = 1; expRdData = bus.dq_in;
            end
            if (mK == T_RP + T_RH) begin
              expDone = 1; mFin = 1;
            end
          end
          3'd4: begin
            // RB_x_n seen two edges late; polling starts the edge after the T_WB blanking
            if (mK > T_WB) begin
              if (mRb2) begin
                expDone = 1; mFin = 1;
              end else if (mK == T_WB + TIMEOUT) begin
                expErr = 1; mFin = 1;
              end
            end
          end
          default: begin
            expErr = 1; mFin = 1;
          end
        endcase
        if (mFin) begin
          mBusy = 0; expReady = 1;
          if (mLast) expCe = 1;
        end
      end else if (expReady && bus.op_valid) begin
        mBusy = 1; mK = 0; mType = bus.op_type; mLast = bus.op_last;
        expReady = 0; expCe = 0;
        if (bus.op_type <= 3'd2) begin
          expCle = (bus.op_type == 3'd0);
          expAle = (bus.op_type == 3'd1);
          expDqOut = bus.op_data; expOe = 1; expWe = 0;
        end else if (bus.op_type == 3'd3) begin
          expOe = 0; expRe = 0;
        end
      end else begin
        expReady = 1;
      end
      mRb2 = mRb1;
      mRb1 = bus.RB_x_n;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("op_ready", int'(bus.op_ready), int'(expReady));
      checkOutput("rd_valid", int'(bus.rd_valid), int'(expRdValid));
      checkOutput("rd_data",  int'(bus.rd_data),  int'(expRdData));
      checkOutput("done",     int'(bus.done),     int'(expDone));
      checkOutput("err",      int'(bus.err),      int'(expErr));
      checkOutput("CE_x_n",   int'(bus.CE_x_n),   int'(expCe));
      checkOutput("CLE_x",    int'(bus.CLE_x),    int'(expCle));
      checkOutput("ALE_x",    int'(bus.ALE_x),    int'(expAle));
      checkOutput("WE_x_n",   int'(bus.WE_x_n),   int'(expWe));
      checkOutput("RE_x_n",   int'(bus.RE_x_n),   int'(expRe));
      checkOutput("WP_x_n",   int'(bus.WP_x_n),   int'(expWp));
      checkOutput("dq_out",   int'(bus.dq_out),   int'(expDqOut));
      checkOutput("dq_oe",    int'(bus.dq_oe),    int'(expOe));
    end
  end

  // Waits for op_ready at a falling edge, presents the op for exactly one accept edge.
  task automatic applyStimulus(input logic [2:0] t, input logic [7:0] d, input logic l);
    int n = 0;
    while (!bus.op_ready) begin
      if (n >= 50) begin
        checkOutput("ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      n++;
    end
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_data  = d;
    bus.op_last  = l;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  // Counts edges from acceptance to done/err; optionally raises RB_x_n after riseAt edges.
  task automatic waitDone(input int riseAt, output int lat, output bit sawErr);
    lat = 0;
    while (!(bus.done || bus.err)) begin
      if (lat == riseAt) bus.RB_x_n = 1'b1;
      if (lat >= 100) begin
        checkOutput("done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      lat++;
    end
    sawErr = bus.err;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit sawErr;
    bus.op_valid = 1'b0;
    bus.op_type  = 3'd0;
    bus.op_data  = 8'h00;
    bus.op_last  = 1'b0;
    bus.wp_en    = 1'b0;
    bus.RB_x_n   = 1'b1;
    bus.dq_in    = 8'h00;

    #1 rst = 1'b1;
    #1 checkEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_ce", int'(bus.CE_x_n), 1);
    checkOutput("rst_ready", int'(bus.op_ready), 0);
    checkOutput("rst_we", int'(bus.WE_x_n), 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", int'(bus.op_ready), 1);

    $display("[TB] CMD 0x70");
    applyStimulus(3'd0, 8'h70, 1'b0);
    waitDone(-1, lat, sawErr);
    checkOutput("cmd_latency", lat, 4);
    checkOutput("cmd_ce_held", int'(bus.CE_x_n), 0);

    $display("[TB] ADDR 0x12, ADDR 0x34 back-to-back");
    applyStimulus(3'd1, 8'h12, 1'b0);
    waitDone(-1, lat, sawErr);
    checkOutput("addr1_latency", lat, 4);
    applyStimulus(3'd1, 8'h34, 1'b1);
    waitDone(-1, lat, sawErr);
    checkOutput("addr2_latency", lat, 4);
    checkOutput("addr2_ce_release", int'(bus.CE_x_n), 1);

    $display("[TB] DOUT reads");
    bus.dq_in = 8'hE0;
    applyStimulus(3'd3, 8'h00, 1'b0);
    waitDone(-1, lat, sawErr);
    checkOutput("dout_latency", lat, 4);
    checkOutput("dout_data_e0", int'(bus.rd_data), 8'hE0);
    bus.dq_in = 8'h5A;
    applyStimulus(3'd3, 8'h00, 1'b1);
    waitDone(-1, lat, sawErr);
    checkOutput("dout_data_5a", int'(bus.rd_data), 8'h5A);
    bus.dq_in = 8'h00;

    $display("[TB] WAIT_RB ready and timeout");
    bus.RB_x_n = 1'b0;
    applyStimulus(3'd4, 8'h00, 1'b0);
    waitDone(9, lat, sawErr);
    checkOutput("rb_latency", lat, 12);
    checkOutput("rb_no_err", int'(sawErr), 0);
    bus.RB_x_n = 1'b0;
    applyStimulus(3'd4, 8'h00, 1'b1);
    waitDone(-1, lat, sawErr);
    checkOutput("to_latency", lat, T_WB + TIMEOUT);
    checkOutput("to_err", int'(sawErr), 1);
    checkOutput("to_no_done", int'(bus.done), 0);
    checkOutput("to_ce_release", int'(bus.CE_x_n), 1);
    bus.RB_x_n = 1'b1;

    $display("[TB] reset during DIN write pulse");
    applyStimulus(3'd2, 8'hA5, 1'b0);
    checkOutput("din_we_low", int'(bus.WE_x_n), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_we", int'(bus.WE_x_n), 1);
    checkOutput("async_rst_ce", int'(bus.CE_x_n), 1);
    checkOutput("async_rst_oe", int'(bus.dq_oe), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'd0, 8'hFF, 1'b1);
    waitDone(-1, lat, sawErr);
    checkOutput("post_rst_latency", lat, 4);
    checkOutput("post_rst_ce", int'(bus.CE_x_n), 1);

    $display("[TB] illegal op and write protect");
    applyStimulus(3'd6, 8'h00, 1'b1);
    waitDone(-1, lat, sawErr);
    checkOutput("illegal_latency", lat, 1);
    checkOutput("illegal_err", int'(sawErr), 1);
    bus.wp_en = 1'b1;
    @(negedge clk);
    checkOutput("wp_follow", int'(bus.WP_x_n), 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
